gcd_unit: RTL and testbench
===========================

# gcd_unit

Parametrised iterative greatest-common-divisor engine with selectable algorithm and a per-result iteration count. It is the successor to the fixed 16-bit subtractive GCD core and keeps the same val/rdy request and response handshake. It adds a binary (Stein) mode, defined zero-operand behaviour and a saturating cycle-count output for performance characterisation. It sits behind any producer/consumer pair that speaks the team's val/rdy message protocol.

## Interface
- XLEN, 16, operand and result width (≥2)
- CNT_W, 8, width of iteration counter output
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_msg  in  2*XLEN  {a, b}; a = req_msg[2*XLEN-1:XLEN], b = req_msg[XLEN-1:0], unsigned
- req_mode  in  1  0 = subtractive Euclid, 1 = binary Stein; sampled with req_msg
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_msg  out  XLEN  gcd(a, b)
- resp_cycles  out  CNT_W  number of CALC cycles used, saturating at 2^CNT_W-1

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE. After reset: req_rdy=1, resp_val=0, resp_msg=0, resp_cycles=0.
- IDLE: req_rdy=1. On req_val&&req_rdy, latch a, b and mode; clear k and the counter; go to CALC.
- CALC: req_rdy=0, resp_val=0. Exactly one step per cycle. Every CALC cycle, including the terminating one, increments the counter (saturating).
- Euclid step, in priority order:
  - a<b: swap.
  - else b≠0: a←a−b.
  - else: result=a; go to DONE.
- Stein step, in priority order:
  - a=0: result=b<<k; done.
  - else b=0: result=a<<k; done.
  - both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - a≥b: a←(a−b)>>1.
  - else: b←(b−a)>>1.
- k has width $clog2(XLEN)+1. The shifted result fits in XLEN by construction.
- gcd(0,0)=0 in both modes. gcd(x,0)=gcd(0,x)=x.
- DONE: resp_val=1. resp_msg and resp_cycles hold stable until resp_rdy. On resp_val&&resp_rdy, go to IDLE.
- resp_msg and resp_cycles retain their last values in IDLE and CALC; they are updated only on entry to DONE.
- Reset mid-CALC or mid-DONE: the in-flight operation is dropped, the FSM returns to IDLE, and all outputs return to their reset values the next cycle.

## Timing
- Accept at edge E0. CALC occupies cycles E0..E(N−1). resp_val rises after edge EN, where N = resp_cycles.
- Minimum latency is 1 CALC cycle, e.g. Euclid (x,0) or Stein (0,x).
- No request/response overlap: req_rdy=0 from the cycle after acceptance until the cycle after the response handshake.
- req_rdy and resp_val are pure functions of state (Moore). Neither depends combinationally on req_val or resp_rdy.
- Backpressure: DONE persists indefinitely while resp_rdy=0.

## Structure
- gcd_pkg holds:
  - state_e enum {IDLE, CALC, DONE}
  - mode_e enum {MODE_EUCLID=0, MODE_STEIN=1}
  - a localparam helper for the k width
- One sub-module, gcd_step. It is combinational next-(a, b, k, done, result) for both modes and is parametrised by XLEN. gcd_unit owns the registers, FSM and counter.

## Test plan
- Euclid (48,18), resp_rdy=1 → resp_msg=6, resp_cycles=9; resp_val 9 cycles after acceptance.
- Stein (48,18) → resp_msg=6, resp_cycles=7. Euclid (17,289) → 17, resp_cycles=20.
- Zeros:
  - Euclid (0,5) → 5 in 2 cycles.
  - Stein (0,5) → 5 in 1 cycle.
  - Euclid (0,0) → 0 in 1 cycle.
  - Stein (0,0) → 0 in 1 cycle.
- Backpressure: hold resp_rdy=0 for 5 cycles in DONE. resp_val, resp_msg and resp_cycles stay stable, req_rdy stays 0 and a req_val pulse is ignored. Release → IDLE the next cycle.
- Reset asserted 3 cycles into Euclid (22000,19900) → IDLE with reset outputs. A following request (1701,199) → resp_msg=1, and the result matches the Stein-mode result.
- Saturation with CNT_W=4: Euclid (289,17) → resp_cycles=15, resp_msg=17.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and sizing helpers for the iterative GCD engine.
// Holds FSM state encoding, algorithm select and the Stein shift width.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_EUCLID = 1'b0,
    MODE_STEIN  = 1'b1
  } mode_e;

  function automatic int k_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/gcd_if.sv
// gcd_if: val/rdy request and response channels of the GCD engine.
// master drives requests and consumes responses; slave is the engine.
interface gcd_if #(
  parameter int XLEN  = 16,
  parameter int CNT_W = 8
);

  logic              req_val;
  logic              req_rdy;
  logic [2*XLEN-1:0] req_msg;
  logic              req_mode;
  logic              resp_val;
  logic              resp_rdy;
  logic [XLEN-1:0]   resp_msg;
  logic [CNT_W-1:0]  resp_cycles;

  modport master (
    output req_val, req_msg, req_mode, resp_rdy,
    input  req_rdy, resp_val, resp_msg, resp_cycles
  );

  modport slave (
    input  req_val, req_msg, req_mode, resp_rdy,
    output req_rdy, resp_val, resp_msg, resp_cycles
  );

endinterface

// File: rtl/gcd_step.sv
// gcd_step: one combinational iteration of Euclid or Stein GCD.
// Produces next operands, shift count, done flag and final result.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int KW   = k_width(XLEN)
) (
  input  mode_e           mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [KW-1:0]   k,
  output logic [XLEN-1:0] a_nxt,
  output logic [XLEN-1:0] b_nxt,
  output logic [KW-1:0]   k_nxt,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] d_ab;
  logic [XLEN-1:0] d_ba;

  assign d_ab = a - b;
  assign d_ba = b - a;

  always_comb begin
    a_nxt  = a;
    b_nxt  = b;
    k_nxt  = k;
    done   = 1'b0;
    result = '0;
    if (mode == MODE_EUCLID) begin
      if (a < b) begin
        a_nxt = b;
        b_nxt = a;
      end else if (b != '0) begin
        a_nxt = d_ab;
      end else begin
        done   = 1'b1;
        result = a;
      end
    end else begin
      // common factors of two are restored by the final shift
      if (a == '0) begin
        done   = 1'b1;
        result = b << k;
      end else if (b == '0) begin
        done   = 1'b1;
        result = a << k;
      end else if (!a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + KW'(1);
      end else if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (a >= b) begin
        a_nxt = d_ab >> 1;
      end else begin
        b_nxt = d_ba >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: iterative GCD engine with Euclid/Stein select and a
// saturating per-result iteration count behind val/rdy channels.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int XLEN  = 16,
  parameter int CNT_W = 8
) (
  input logic  clk,
  input logic  reset,
  gcd_if.slave io
);

  localparam int KW = k_width(XLEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  mode_e            mode_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [XLEN-1:0]  res_q;
  logic [CNT_W-1:0] cyc_q;

  logic [XLEN-1:0]  a_nxt;
  logic [XLEN-1:0]  b_nxt;
  logic [KW-1:0]    k_nxt;
  logic             done;
  logic [XLEN-1:0]  result;

  gcd_step #(
    .XLEN (XLEN),
    .KW   (KW)
  ) u_step (
    .mode   (mode_q),
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_nxt  (a_nxt),
    .b_nxt  (b_nxt),
    .k_nxt  (k_nxt),
    .done   (done),
    .result (result)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q
                 : cnt_q + CNT_W'(1);

  assign io.req_rdy     = (state == IDLE);
  assign io.resp_val    = (state == DONE);
  assign io.resp_msg    = res_q;
  assign io.resp_cycles = cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= MODE_EUCLID;
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      cyc_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.req_val) begin
            a_q    <= io.req_msg[2*XLEN-1:XLEN];
            b_q    <= io.req_msg[XLEN-1:0];
            mode_q <= mode_e'(io.req_mode);
            k_q    <= '0;
            cnt_q  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          k_q   <= k_nxt;
          cnt_q <= cnt_inc;
          if (done) begin
            res_q <= result;
            cyc_q <= cnt_inc;
            state <= DONE;
          end
        end
        DONE: begin
          if (io.resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: randomized scoreboard bench for gcd_unit with an
// arithmetic reference model and directed corner cases.
module tb_gcd_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  gcd_if #(.XLEN(16), .CNT_W(8)) io ();
  gcd_if #(.XLEN(16), .CNT_W(4)) sio ();

  gcd_unit #(.XLEN(16), .CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  gcd_unit #(.XLEN(16), .CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .io    (sio.slave)
  );

  typedef struct {
    int unsigned msg;
    int unsigned cyc;
    int unsigned steps;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_n = 0;
  int          checks = 0;
  int          fails = 0;
  bit          prev_val = 1'b0;
  int unsigned rise_at = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name,
                       input int unsigned act,
                       input int unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // gcd by remainders; step count by walking the algorithm's rules
  function automatic void model(input int unsigned a0,
                                input int unsigned b0,
                                input bit mode,
                                output int unsigned g,
                                output int unsigned steps);
    int unsigned x, y, t, a, b;
    x = a0;
    y = b0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    a = a0;
    b = b0;
    steps = 0;
    while (1) begin
      steps++;
      if (!mode) begin
        if (a < b) begin
          t = a; a = b; b = t;
        end else if (b != 0) a = a - b;
        else break;
      end else begin
        if (a == 0 || b == 0) break;
        else if (a % 2 == 0 && b % 2 == 0) begin
          a = a / 2; b = b / 2;
        end else if (a % 2 == 0) a = a / 2;
        else if (b % 2 == 0) b = b / 2;
        else if (a >= b) a = (a - b) / 2;
        else b = (b - a) / 2;
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_val = 1'b0;
    end else begin
      if (io.resp_val && !prev_val) rise_at = cyc_n;
      prev_val = io.resp_val;
      if (io.resp_val && io.resp_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_resp: got %0d expected none",
                   io.resp_msg);
        end else begin
          e = sb.pop_front();
          check("resp_msg", io.resp_msg, e.msg);
          check("resp_cycles", io.resp_cycles, e.cyc);
          check("latency", rise_at - e.acc, e.steps);
        end
      end
    end
  end

  task automatic send(input int unsigned a,
                      input int unsigned b,
                      input bit mode,
                      input int unsigned g,
                      input int unsigned s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!io.req_rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!io.req_rdy) begin
      checks++;
      fails++;
      $display("FAIL req_rdy_timeout: got 0 expected 1");
      return;
    end
    io.req_msg  = {a[15:0], b[15:0]};
    io.req_mode = mode;
    io.req_val  = 1'b1;
    e.msg   = g;
    e.steps = s;
    e.cyc   = (s > 255) ? 255 : s;
    e.acc   = cyc_n + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 io.req_val = 1'b0;
  endtask

  task automatic send_m(input int unsigned a,
                        input int unsigned b,
                        input bit mode);
    int unsigned g, s;
    model(a, b, mode, g, s);
    send(a, b, mode, g, s);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !io.req_rdy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_rdy"}, io.req_rdy, 1);
    check({tag, "_resp_val"}, io.resp_val, 0);
    check({tag, "_resp_msg"}, io.resp_msg, 0);
    check({tag, "_resp_cycles"}, io.resp_cycles, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned g, s, ra, rb;
    int          n;
    io.req_val   = 1'b0;
    io.req_msg   = '0;
    io.req_mode  = 1'b0;
    io.resp_rdy  = 1'b1;
    sio.req_val  = 1'b0;
    sio.req_msg  = '0;
    sio.req_mode = 1'b0;
    sio.resp_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outs("rst");

    send(48, 18, 0, 6, 9);
    send(48, 18, 1, 6, 7);
    send(17, 289, 0, 17, 20);
    send(0, 5, 0, 5, 2);
    send(0, 5, 1, 5, 1);
    send(0, 0, 0, 0, 1);
    send(0, 0, 1, 0, 1);
    drain();

    // hold the response and poke a request that must be ignored
    io.resp_rdy = 1'b0;
    send(48, 18, 0, 6, 9);
    n = 0;
    while (!io.resp_val && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_val", io.resp_val, 1);
      check("bp_resp_msg", io.resp_msg, 6);
      check("bp_resp_cycles", io.resp_cycles, 9);
      check("bp_req_rdy", io.req_rdy, 0);
      if (i == 1) begin
        io.req_msg = {16'd7, 16'd3};
        io.req_val = 1'b1;
      end else begin
        io.req_val = 1'b0;
      end
    end
    @(posedge clk);
    #1 io.resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_req_rdy", io.req_rdy, 1);
    check("bp_rel_resp_val", io.resp_val, 0);

    // abort a long Euclid run with reset
    send(22000, 19900, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete(sb.size() - 1);
    @(posedge clk);
    #1;
    check_reset_outs("abort");
    reset = 1'b0;

    model(1701, 199, 0, g, s);
    send(1701, 199, 0, 1, s);
    model(1701, 199, 1, g, s);
    send(1701, 199, 1, 1, s);
    drain();

    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      send_m(ra, rb, 0);
    end
    for (int i = 0; i < 25; i++) begin
      ra = $urandom & 32'hffff;
      rb = $urandom & 32'hffff;
      if (i % 8 == 3) rb = 0;
      send_m(ra, rb, 1);
    end
    drain();

    // narrow counter saturates
    @(negedge clk);
    sio.req_msg  = {16'd289, 16'd17};
    sio.req_mode = 1'b0;
    sio.req_val  = 1'b1;
    @(posedge clk);
    #1 sio.req_val = 1'b0;
    n = 0;
    while (!sio.resp_val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sat_resp_val", sio.resp_val, 1);
    check("sat_resp_msg", sio.resp_msg, 17);
    check("sat_resp_cycles", sio.resp_cycles, 15);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
